branch_flush_ctrl: RTL and testbench

//  Execute-stage branch sequencer and flags-register owner for the 16-bit pipelined core.
//  - Holds the architectural flags {CF,ZF,SF,OF} that feed the condition unit as FlagsE.
//  - On a taken branch, redirects the PC and sequences a multi-cycle flush of the wrong-path

---
 rtl/branch_flush_ctrl.sv | 114 +++++++++++
 tb/tb_branch_flush_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_flush_ctrl
// Brief   : Execute-stage branch sequencer, flags register and branch counters
// Revision: 1.0
// ============================================================================
module branch_flush_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             BranchE,
    input  logic             CondExE,
    input  logic [3:0]       Flags_prim,
    output logic [3:0]       FlagsE,
    output logic             PCSrcE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Busy,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] C_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             flush_q;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    logic w_valid;
    logic w_taken;

    // A stalled or squashed slot never qualifies, so X on BranchE/CondExE is masked here.
    assign w_valid = (state_q == S_RUN) && !StallE;
    assign w_taken = w_valid && BranchE && CondExE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (w_taken) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= C_FLUSH_LAST;
                        flush_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= 4'd0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        flags_d = flags_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        if (w_valid && CondExE) begin
            flags_d = Flags_prim;
        end
        if (w_valid && BranchE && (bcnt_q != {CNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end
        if (w_taken && (tcnt_q != {CNT_W{1'b1}})) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'd0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            flags_q <= flags_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign PCSrcE      = w_taken && !reset;
    assign FlushD      = flush_q;
    assign FlushE      = flush_q;
    assign Busy        = flush_q;
    assign FlagsE      = flags_q;
    assign BranchCount = bcnt_q;
    assign TakenCount  = tcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_flush_ctrl
// Brief   : Directed self-checking bench for branch_flush_ctrl
// Revision: 1.0
// ============================================================================
module tb_branch_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br, cond;
    logic [3:0]  fp;
    logic        s_stall, s_br, s_cond;
    logic [3:0]  s_fp;

    logic [3:0]  flags0, flags1;
    logic        pcs0, fd0, fe0, busy0;
    logic        pcs1, fd1, fe1, busy1;
    logic [15:0] bc0, tc0;
    logic [3:0]  bc1, tc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .StallE(stall), .BranchE(br), .CondExE(cond),
        .Flags_prim(fp), .FlagsE(flags0), .PCSrcE(pcs0), .FlushD(fd0), .FlushE(fe0),
        .Busy(busy0), .BranchCount(bc0), .TakenCount(tc0)
    );

    branch_flush_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .StallE(s_stall), .BranchE(s_br), .CondExE(s_cond),
        .Flags_prim(s_fp), .FlagsE(flags1), .PCSrcE(pcs1), .FlushD(fd1), .FlushE(fe1),
        .Busy(busy1), .BranchCount(bc1), .TakenCount(tc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush0(input string tag, input logic exp);
        chk({tag, "_fd"}, 32'(fd0), 32'(exp));
        chk({tag, "_fe"}, 32'(fe0), 32'(exp));
        chk({tag, "_busy"}, 32'(busy0), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; br = 1'b1; cond = 1'b1; fp = 4'hF;
        s_stall = 1'b0; s_br = 1'b0; s_cond = 1'b0; s_fp = 4'h0;
        tick(); tick();
        chk("rst_pcsrc_held", 32'(pcs0), 32'd0);
        flush0("rst", 1'b0);
        chk("rst_flags", 32'(flags0), 32'd0);
        chk("rst_bc", 32'(bc0), 32'd0);
        chk("rst_tc", 32'(tc0), 32'd0);
        br = 1'b0; cond = 1'b0;
        reset = 1'b0;
        tick();

        // Not taken: counted, no redirect, flags held
        br = 1'b1; cond = 1'b0; fp = 4'hF;
        #1;
        chk("nt_pcsrc", 32'(pcs0), 32'd0);
        tick();
        flush0("nt", 1'b0);
        chk("nt_bc", 32'(bc0), 32'd1);
        chk("nt_tc", 32'(tc0), 32'd0);
        chk("nt_flags", 32'(flags0), 32'd0);

        // Flag-setting op
        br = 1'b0; cond = 1'b1; fp = 4'b0100;
        #1;
        chk("fl_pcsrc", 32'(pcs0), 32'd0);
        tick();
        chk("fl_flags", 32'(flags0), 32'b0100);
        chk("fl_bc", 32'(bc0), 32'd1);

        // Taken branch at cycle N
        br = 1'b1; cond = 1'b1; fp = 4'b0010;
        #1;
        chk("tk_pcsrc_N", 32'(pcs0), 32'd1);
        tick();
        flush0("tk_N1", 1'b1);
        chk("tk_bc", 32'(bc0), 32'd2);
        chk("tk_tc", 32'(tc0), 32'd1);
        chk("tk_flags", 32'(flags0), 32'b0010);
        // Wrong-path branch and flag write inside FLUSH
        br = 1'b1; cond = 1'b1; fp = 4'b1001;
        #1;
        chk("fl1_pcsrc", 32'(pcs0), 32'd0);
        tick();
        flush0("tk_N2", 1'b1);
        chk("fl1_bc", 32'(bc0), 32'd2);
        chk("fl1_flags", 32'(flags0), 32'b0010);
        // Branch on the cnt==0 cycle is ignored
        #1;
        chk("fl0_pcsrc", 32'(pcs0), 32'd0);
        tick();
        flush0("tk_N3", 1'b0);
        chk("fl0_bc", 32'(bc0), 32'd2);
        chk("fl0_tc", 32'(tc0), 32'd1);
        // Back-to-back taken
        fp = 4'b0001;
        #1;
        chk("b2b_pcsrc", 32'(pcs0), 32'd1);
        tick();
        flush0("b2b", 1'b1);
        chk("b2b_bc", 32'(bc0), 32'd3);
        chk("b2b_tc", 32'(tc0), 32'd2);
        chk("b2b_flags", 32'(flags0), 32'b0001);

        // Reset mid-flush drops everything asynchronously
        br = 1'b0; cond = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        flush0("mid_rst", 1'b0);
        chk("mid_rst_flags", 32'(flags0), 32'd0);
        chk("mid_rst_bc", 32'(bc0), 32'd0);
        chk("mid_rst_tc", 32'(tc0), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Stalled taken branch, including X on branch inputs
        stall = 1'b1; br = 1'b1; cond = 1'b1; fp = 4'b1100;
        #1;
        chk("st_pcsrc", 32'(pcs0), 32'd0);
        tick();
        chk("st1_bc", 32'(bc0), 32'd0);
        br = 1'bx; cond = 1'bx;
        #1;
        chk("stx_pcsrc", 32'(pcs0), 32'd0);
        tick();
        chk("stx_busy", 32'(busy0), 32'd0);
        chk("stx_flags", 32'(flags0), 32'd0);
        br = 1'b1; cond = 1'b1;
        tick();
        chk("st3_tc", 32'(tc0), 32'd0);
        stall = 1'b0;
        #1;
        chk("st_rel_pcsrc", 32'(pcs0), 32'd1);
        tick();
        chk("st_rel_bc", 32'(bc0), 32'd1);
        chk("st_rel_tc", 32'(tc0), 32'd1);
        chk("st_rel_flags", 32'(flags0), 32'b1100);
        flush0("st_rel", 1'b1);
        br = 1'b0; cond = 1'b0;
        tick(); tick();
        flush0("st_done", 1'b0);

        // FLUSH_CYCLES=1 instance: single flush cycle, then saturation
        s_br = 1'b1; s_cond = 1'b1; s_fp = 4'b1010;
        #1;
        chk("f1_pcsrc", 32'(pcs1), 32'd1);
        tick();
        chk("f1_busy", 32'(busy1), 32'd1);
        chk("f1_fd", 32'(fd1), 32'd1);
        chk("f1_fe", 32'(fe1), 32'd1);
        chk("f1_bc", 32'(bc1), 32'd1);
        chk("f1_flags", 32'(flags1), 32'b1010);
        chk("f1_ign_pcsrc", 32'(pcs1), 32'd0);
        tick();
        chk("f1_run_busy", 32'(busy1), 32'd0);
        chk("f1_ign_bc", 32'(bc1), 32'd1);
        chk("f1_b2b_pcsrc", 32'(pcs1), 32'd1);
        // 19 further taken branches, one every other cycle
        for (int i = 0; i < 38; i++) tick();
        chk("sat_bc", 32'(bc1), 32'hF);
        chk("sat_tc", 32'(tc1), 32'hF);
        s_br = 1'b0; s_cond = 1'b0;
        tick(); tick();
        chk("sat_hold_bc", 32'(bc1), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
